fir_result_reader: RTL and testbench

Streams filtered results out of the FIR sample memory after a filter run. On `start` it reads `count` consecutive bytes beginning at `base_addr` through the memory's registered-read port. It presents them on a valid/ready byte stream with a last-beat flag, and pulses `done` when the final byte has been accepted. It is the read-out counterpart to the sample loader. It sits beside `fir_top` on the memory's read port and gives testbenches and host logic one way to pull results back out.

---
 rtl/fir_result_reader.sv | 161 ++++++++++++++++
 tb/tb_fir_result_reader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_result_reader.sv
// fir_result_reader
//   Streams a block of bytes out of the FIR sample memory after a filter run.
//   On start it reads `count` consecutive bytes from `base_addr` through the
//   memory's registered-read port and presents them on a valid/ready stream.
//   A 2-entry FIFO absorbs the one-cycle read latency. The word returning
//   from memory bypasses the empty FIFO, so the first beat appears two
//   cycles after start.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start               begin a read-out (sampled in IDLE only)
//   base_addr, count    run parameters, captured when start is accepted
//   busy, done          run in progress / one-cycle end-of-run pulse
//   mem_en, mem_addr    read strobe and address to the sample memory
//   mem_rdata           read data, valid the cycle after mem_en
//   m_data, m_valid     output byte stream
//   m_ready, m_last     consumer ready / final beat of the run
module fir_result_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   issued_rem_q, issued_rem_d;
    logic [ADDR_W:0]   beats_rem_q, beats_rem_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // FIFO bookkeeping; the two data slots live in fifo_q.
    logic [DATA_W-1:0] fifo_q [2];
    logic [1:0]        occ_q, occ_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;

    logic              pop;
    logic              pop_fifo;
    logic              push;
    logic              issue;
    logic              last_pop;
    logic [2:0]        level;

    // The returning read counts as "present" even before it lands in the FIFO.
    assign m_valid  = (occ_q != 2'd0) || inflight_q;
    assign m_data   = (occ_q != 2'd0) ? fifo_q[rd_ptr_q]
                    : (inflight_q ? mem_rdata : '0);
    assign m_last   = m_valid && (beats_rem_q == (ADDR_W+1)'(1));
    assign pop      = m_valid && m_ready;
    // A pop with an empty FIFO consumes the bypassed word directly.
    assign pop_fifo = pop && (occ_q != 2'd0);
    assign push     = inflight_q && !(occ_q == 2'd0 && pop);
    assign last_pop = pop && (beats_rem_q == (ADDR_W+1)'(1));

    // Entries held after this cycle; a new read may only be issued if the
    // word it returns next cycle still has a slot to land in.
    assign level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue    = (state_q == S_READ) && (issued_rem_q != '0) && (level <= 3'd1);

    assign mem_en   = issue;
    assign mem_addr = rd_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        rd_addr_d    = issue ? rd_addr_q + 1'b1 : rd_addr_q;
        issued_rem_d = issue ? issued_rem_q - 1'b1 : issued_rem_q;
        beats_rem_d  = pop ? beats_rem_q - 1'b1 : beats_rem_q;
        inflight_d   = issue;
        busy_d       = busy_q;
        occ_d        = occ_q + {1'b0, push} - {1'b0, pop_fifo};
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop_fifo;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_addr_d    = base_addr;
                    issued_rem_d = count;
                    beats_rem_d  = count;
                    busy_d       = 1'b1;
                    state_d      = (count == '0) ? S_FINISH : S_READ;
                end
            end
            S_READ: begin
                if (issue && issued_rem_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // The last accepted beat empties the FIFO with nothing in flight.
                if (last_pop) begin
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= '0;
            issued_rem_q <= '0;
            beats_rem_q  <= '0;
            inflight_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            occ_q        <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            issued_rem_q <= issued_rem_d;
            beats_rem_q  <= beats_rem_d;
            inflight_q   <= inflight_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            occ_q        <= occ_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // NOTE: FIFO data slots are not reset; occupancy gates them, so their contents never matter when empty.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= mem_rdata;
    end

endmodule

// File: tb/tb_fir_result_reader.sv
// Bench for fir_result_reader: directed runs against a sample memory model,
// with a per-cycle reference model of the expected stream.
module tb_fir_result_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count = '0;
    logic              busy, done, mem_en, m_valid, m_last;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] m_data;

    logic [7:0] mem [1024];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_result_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    // Registered-read sample memory.
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready: fixed level, or the 1,0,0,1 repeating pattern.
    bit toggle_mode = 1'b0;
    bit ready_level = 1'b1;
    int ph = 0;
    always @(posedge clk) begin
        #1;
        if (toggle_mode) begin
            m_ready = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
        end else begin
            m_ready = ready_level;
        end
    end

    // Reference model: the run's expected bytes as a queue, plus run status.
    logic [7:0]        exp_q[$];
    logic [7:0]        got[$];
    bit                model_active = 1'b0;
    bit                done_pending = 1'b0;
    bit                zero_run = 1'b0;
    bit                stalled = 1'b0;
    bit                done_cycle;
    logic [7:0]        stall_data = '0;
    logic [ADDR_W-1:0] exp_addr = '0;
    int                issued = 0;
    int                accepted = 0;
    int                run_count = 0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            model_active = 1'b0;
            done_pending = 1'b0;
            zero_run     = 1'b0;
            stalled      = 1'b0;
            issued       = 0;
            accepted     = 0;
        end else begin
            done_cycle = done_pending;
            check("busy", busy, model_active && (!done_pending || zero_run));
            check("done", done, done_pending);
            if (done_pending) begin
                done_pending = 1'b0;
                model_active = 1'b0;
                zero_run     = 1'b0;
            end

            if (m_valid) begin
                if (exp_q.size() == 0) check("spurious_valid", 1, 0);
                else begin
                    check("m_data", m_data, exp_q[0]);
                    check("m_last", m_last, exp_q.size() == 1);
                end
                if (stalled) check("stall_hold", m_data, stall_data);
                if (m_ready) begin
                    got.push_back(m_data);
                    if (exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0 && model_active) done_pending = 1'b1;
                    end
                    accepted++;
                    stalled = 1'b0;
                end else begin
                    stalled    = 1'b1;
                    stall_data = m_data;
                end
            end else begin
                if (stalled) check("valid_dropped", 0, 1);
                stalled = 1'b0;
                check("m_last_idle", m_last, 0);
            end

            if (mem_en) begin
                check("mem_en_allowed", model_active && issued < run_count, 1);
                check("mem_addr", mem_addr, exp_addr);
                exp_addr = exp_addr + 1'b1;
                issued++;
                check("buffered_le_2", (issued - accepted) <= 2, 1);
            end

            if (start && !model_active && !done_cycle) begin
                exp_q.delete();
                for (int i = 0; i < int'(count); i++)
                    exp_q.push_back(mem[(int'(base_addr) + i) % 1024]);
                model_active = 1'b1;
                exp_addr     = base_addr;
                issued       = 0;
                accepted     = 0;
                run_count    = int'(count);
                if (count == '0) begin
                    done_pending = 1'b1;
                    zero_run     = 1'b1;
                end
            end
        end
    end

    // Pulse start for one cycle, then wait (bounded) for done.
    // fv/dn are cycle numbers relative to the start cycle (cycle 0).
    task automatic run(input int b, input int c, output int fv, output int dn);
        int n;
        fv = -1;
        dn = -1;
        got.delete();
        base_addr = ADDR_W'(b);
        count     = (ADDR_W+1)'(c);
        start     = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (m_valid && fv < 0) fv = n;
            if (done) begin
                dn = n;
                break;
            end
        end
        if (dn < 0) check("run_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] lit16 [16];
    logic [7:0] litw  [8];
    int fv, dn, n;

    initial begin
        lit16 = '{8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd0, 8'd0, 8'd0,
                  8'd0, 8'd0, 8'd32, 8'd32, 8'd32, 8'd32, 8'd32, 8'd0};
        litw  = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        for (int i = 0; i < 5; i++) begin
            mem[i]      = 8'd64;
            mem[10 + i] = 8'd32;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Full-rate run: 16 beats, first valid at cycle 2, done at cycle 18.
        run(0, 16, fv, dn);
        check("full_first_valid", fv, 2);
        check("full_done_cycle", dn, 18);
        check("full_beats", got.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < got.size()) check("full_byte", got[i], lit16[i]);

        // Same run under 1,0,0,1 back-pressure.
        ph = 0;
        toggle_mode = 1'b1;
        run(0, 16, fv, dn);
        toggle_mode = 1'b0;
        check("bp_beats", got.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < got.size()) check("bp_byte", got[i], lit16[i]);

        // Address wrap from 1020.
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        run(1020, 8, fv, dn);
        check("wrap_done_cycle", dn, 10);
        check("wrap_beats", got.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got.size()) check("wrap_byte", got[i], litw[i]);

        // Zero-length run.
        run(5, 0, fv, dn);
        check("zero_done_cycle", dn, 1);
        check("zero_no_valid", fv, -1);
        check("zero_beats", got.size(), 0);

        // start re-pulsed while busy with different parameters.
        got.delete();
        base_addr = 10'd200;
        count     = 11'd4;
        start     = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        base_addr = 10'd300;
        count     = 11'd9;
        start     = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (n < 200 && !done) begin
            @(negedge clk);
            n++;
        end
        check("repulse_timeout", n < 200, 1);
        @(posedge clk); #1;
        check("repulse_beats", got.size(), 4);
        if (got.size() == 4) begin
            check("repulse_first", got[0], 8'hC8);
            check("repulse_last", got[3], 8'hCB);
        end

        // Reset mid-run after beat 3, with a read in flight.
        got.delete();
        base_addr = 10'd0;
        count     = 11'd16;
        start     = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        accepted = 0;
        while (n < 200 && got.size() < 3) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_beat3", n < 200, 1);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_mem_en", mem_en, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_last", m_last, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_m_data", m_data, 0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        mem[100] = 8'hA5;
        mem[101] = 8'h5A;
        run(100, 2, fv, dn);
        check("post_rst_done_cycle", dn, 4);
        check("post_rst_beats", got.size(), 2);
        if (got.size() == 2) begin
            check("post_rst_b0", got[0], 8'hA5);
            check("post_rst_b1", got[1], 8'h5A);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
